// File: rtl/hci_mem_sram_adapter_pkg.sv
// Shared types and default parameters for the HCI-to-SRAM bank adapter.
package hci_mem_sram_adapter_pkg;

   typedef enum logic [1:0] {
      BANK_ACTIVE = 2'd0,
      BANK_SLEEP  = 2'd1,
      BANK_WAKE   = 2'd2
   } hci_bank_state_e;

   localparam int DEFAULT_RD_LAT      = 1;
   localparam int DEFAULT_WAKE_CYCLES = 4;
   localparam int DEFAULT_IDLE_CYCLES = 64;

endpackage

// File: rtl/hci_mem_sram_adapter_if.sv
// HCI memory port bundle.
// Handshake: a request transfers in every cycle where req=1 and gnt=1; the master keeps
// req/add/wen/data/be/id/user stable until it sees gnt. Read responses are pushed with
// r_valid and have no ready: the master must accept r_valid/r_data/r_id/r_user whenever
// r_valid=1, and responses return in request order.
interface hci_mem_sram_adapter_if #(
   parameter int DW = 32,
   parameter int AW = 32,
   parameter int BW = 8,
   parameter int IW = 8,
   parameter int UW = 1
) ();
   logic             req;
   logic             gnt;
   logic [AW-1:0]    add;
   logic             wen;
   logic [DW-1:0]    data;
   logic [DW/BW-1:0] be;
   logic [IW-1:0]    id;
   logic [UW-1:0]    user;
   logic             r_valid;
   logic [DW-1:0]    r_data;
   logic [IW-1:0]    r_id;
   logic [UW-1:0]    r_user;

   modport master (
      output req, add, wen, data, be, id, user,
      input  gnt, r_valid, r_data, r_id, r_user
   );

   modport slave (
      input  req, add, wen, data, be, id, user,
      output gnt, r_valid, r_data, r_id, r_user
   );
endinterface

// File: rtl/hci_mem_sram_adapter_resp_pipe.sv
// Fixed-depth delay line carrying a valid bit plus payload, with synchronous flush.
module hci_mem_sram_adapter_resp_pipe #(
   parameter int DEPTH = 1,
   parameter int PW    = 9
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [PW-1:0] payload_i,
   output logic          valid_o,
   output logic [PW-1:0] payload_o,
   output logic          head_valid_o,
   output logic          busy_o
);
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    payload_q [DEPTH];
   logic [PW-1:0]    payload_d [DEPTH];

   // Shift every stage one step per cycle; a flush kills all in-flight entries.
   always_comb begin
      valid_d      = '0;
      payload_d    = payload_q;
      valid_d[0]   = push_i;
      payload_d[0] = push_i ? payload_i : payload_q[0];
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i]   = valid_q[i-1];
         payload_d[i] = payload_q[i-1];
      end
      if (flush_i) valid_d = '0;
   end

   // Stage registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) payload_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign valid_o      = valid_q[DEPTH-1];
   assign payload_o    = payload_q[DEPTH-1];
   assign head_valid_o = valid_q[0];
   assign busy_o       = |valid_q;
endmodule

// File: rtl/hci_mem_sram_adapter.sv
// Terminal HCI stage: drives a single-port SRAM macro, returns read data with a fixed
// latency, and parks the bank in retention after a run of idle cycles.
module hci_mem_sram_adapter
   import hci_mem_sram_adapter_pkg::*;
#(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int BW          = 8,
   parameter int IW          = 8,
   parameter int UW          = 1,
   parameter int BANK_AW     = 12,
   parameter int RD_LAT      = DEFAULT_RD_LAT,
   parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
   parameter int WAKE_CYCLES = DEFAULT_WAKE_CYCLES
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   hci_mem_sram_adapter_if.slave in,
   output logic               sram_req_o,
   output logic               sram_we_o,
   output logic [BANK_AW-1:0] sram_addr_o,
   output logic [DW-1:0]      sram_wdata_o,
   output logic [DW/BW-1:0]   sram_be_o,
   input  logic [DW-1:0]      sram_rdata_i,
   output logic               sram_sleep_o,
   output hci_bank_state_e    bank_state_o
);
   localparam int OFF = $clog2(DW/8);
   localparam int ICW = (IDLE_CYCLES < 2) ? 1 : $clog2(IDLE_CYCLES);
   localparam int WCW = $clog2(WAKE_CYCLES + 1);
   localparam int PW  = IW + UW;
   localparam bit SLEEP_EN = (IDLE_CYCLES != 0);
   localparam logic [ICW-1:0] IDLE_MAX  = ICW'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);
   localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYCLES - 1);

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("hci_mem_sram_adapter: RD_LAT must be 1 or 2");
   end
   if (WAKE_CYCLES < 1) begin : g_bad_wake
      $error("hci_mem_sram_adapter: WAKE_CYCLES must be >= 1");
   end
   if (BANK_AW + OFF > AW) begin : g_bad_aw
      $error("hci_mem_sram_adapter: BANK_AW does not fit in AW");
   end

   hci_bank_state_e state_q, state_d;
   logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;
   logic [WCW-1:0]  wake_cnt_q, wake_cnt_d;
   logic            gnt, sleep;
   logic            pipe_busy, pipe_valid, head_valid;
   logic [PW-1:0]   pipe_payload;
   logic            unused_bits;

   // Bank FSM: grant logic, idle counting and the sleep/wake sequence; clear and reset override.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      gnt        = 1'b0;
      sleep      = 1'b0;
      case (state_q)
         BANK_ACTIVE: begin
            gnt = in.req;
            if (in.req || pipe_busy)       idle_cnt_d = '0;
            else if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
            if (SLEEP_EN && idle_cnt_q == IDLE_MAX && !in.req && !pipe_busy)
               state_d = BANK_SLEEP;
         end
         BANK_SLEEP: begin
            sleep      = 1'b1;
            idle_cnt_d = '0;
            if (in.req) begin
               state_d    = BANK_WAKE;
               wake_cnt_d = WAKE_LOAD;
            end
         end
         BANK_WAKE: begin
            idle_cnt_d = '0;
            if (wake_cnt_q == '0) state_d    = BANK_ACTIVE;
            else                  wake_cnt_d = wake_cnt_q - 1'b1;
         end
         default: state_d = BANK_ACTIVE;
      endcase
      if (clear_i) begin
         gnt        = 1'b0;
         state_d    = BANK_ACTIVE;
         idle_cnt_d = '0;
         wake_cnt_d = '0;
      end
      if (rst_i) begin
         gnt   = 1'b0;
         sleep = 1'b0;
      end
   end

   // FSM and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= BANK_ACTIVE;
         idle_cnt_q <= '0;
         wake_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         wake_cnt_q <= wake_cnt_d;
      end
   end

   assign in.gnt       = gnt;
   assign sram_req_o   = gnt;
   assign sram_we_o    = ~in.wen;
   assign sram_addr_o  = in.add[BANK_AW+OFF-1 -: BANK_AW];
   assign sram_wdata_o = in.data;
   assign sram_be_o    = in.be;
   assign sram_sleep_o = sleep;
   assign bank_state_o = state_q;

   hci_mem_sram_adapter_resp_pipe #(.DEPTH(RD_LAT), .PW(PW)) u_resp_pipe (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (clear_i),
      .push_i      (gnt & in.wen),
      .payload_i   ({in.id, in.user}),
      .valid_o     (pipe_valid),
      .payload_o   (pipe_payload),
      .head_valid_o(head_valid),
      .busy_o      (pipe_busy)
   );

   assign in.r_valid = pipe_valid;
   assign in.r_id    = pipe_payload[PW-1 -: IW];
   assign in.r_user  = pipe_payload[UW-1:0];

   if (RD_LAT == 2) begin : g_rdata_reg
      logic [DW-1:0] rdata_q, rdata_d;
      // Capture macro data only in the cycle a live read returns, so r_data holds otherwise.
      always_comb begin
         rdata_d = rdata_q;
         if (head_valid) rdata_d = sram_rdata_i;
      end
      // Read data register.
      always_ff @(posedge clk_i) begin
         if (rst_i) rdata_q <= '0;
         else       rdata_q <= rdata_d;
      end
      assign in.r_data = rdata_q;
   end else begin : g_rdata_comb
      assign in.r_data = sram_rdata_i;
   end

   // Address bits outside the bank window are intentionally ignored.
   assign unused_bits = ^{in.add, head_valid};
endmodule

// File: tb/tb_hci_mem_sram_adapter.sv
// Directed bench for hci_mem_sram_adapter: three instances cover RD_LAT=1, RD_LAT=2 and
// sleep disabled; each drives a small behavioural SRAM macro.
module tb_hci_mem_sram_adapter;
  import hci_mem_sram_adapter_pkg::*;

  logic clk, rst, clear;
  int   checks, errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  hci_mem_sram_adapter_if #(.DW(32), .AW(32), .BW(8), .IW(8), .UW(1)) if1 ();
  hci_mem_sram_adapter_if #(.DW(32), .AW(32), .BW(8), .IW(8), .UW(1)) if2 ();
  hci_mem_sram_adapter_if #(.DW(32), .AW(32), .BW(8), .IW(8), .UW(1)) if0 ();

  logic        req1, we1, sleep1, req2, we2, sleep2, req0, we0, sleep0;
  logic [11:0] addr1, addr2, addr0;
  logic [31:0] wdata1, wdata2, wdata0, rdata1, rdata2;
  logic [3:0]  be1, be2, be0;
  hci_bank_state_e st1, st2, st0;
  logic [31:0] mem1 [4096];
  logic [31:0] mem2 [4096];

  hci_mem_sram_adapter #(.RD_LAT(1), .IDLE_CYCLES(64), .WAKE_CYCLES(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in(if1),
    .sram_req_o(req1), .sram_we_o(we1), .sram_addr_o(addr1), .sram_wdata_o(wdata1),
    .sram_be_o(be1), .sram_rdata_i(rdata1), .sram_sleep_o(sleep1), .bank_state_o(st1));

  hci_mem_sram_adapter #(.RD_LAT(2), .IDLE_CYCLES(64), .WAKE_CYCLES(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in(if2),
    .sram_req_o(req2), .sram_we_o(we2), .sram_addr_o(addr2), .sram_wdata_o(wdata2),
    .sram_be_o(be2), .sram_rdata_i(rdata2), .sram_sleep_o(sleep2), .bank_state_o(st2));

  hci_mem_sram_adapter #(.RD_LAT(1), .IDLE_CYCLES(0), .WAKE_CYCLES(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in(if0),
    .sram_req_o(req0), .sram_we_o(we0), .sram_addr_o(addr0), .sram_wdata_o(wdata0),
    .sram_be_o(be0), .sram_rdata_i(32'h0), .sram_sleep_o(sleep0), .bank_state_o(st0));

  // Behavioural SRAM macros: byte-masked write, read data valid the cycle after access.
  always @(posedge clk) begin
    if (req1) begin
      if (we1) begin
        for (int b = 0; b < 4; b++) if (be1[b]) mem1[addr1][b*8 +: 8] <= wdata1[b*8 +: 8];
      end else begin
        rdata1 <= mem1[addr1];
      end
    end
    if (req2) begin
      if (we2) begin
        for (int b = 0; b < 4; b++) if (be2[b]) mem2[addr2][b*8 +: 8] <= wdata2[b*8 +: 8];
      end else begin
        rdata2 <= mem2[addr2];
      end
    end
  end

  task automatic idle_all();
    if1.req = 0; if1.wen = 1; if1.add = 0; if1.data = 0; if1.be = 0; if1.id = 0; if1.user = 0;
    if2.req = 0; if2.wen = 1; if2.add = 0; if2.data = 0; if2.be = 0; if2.id = 0; if2.user = 0;
    if0.req = 0; if0.wen = 1; if0.add = 0; if0.data = 0; if0.be = 0; if0.id = 0; if0.user = 0;
  endtask

  // Leaves the bench at a negedge in the first cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1; clear = 0;
    idle_all();
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_sleep1();
    int n = 0;
    while (sleep1 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sleep1 !== 1'b1) begin errors++; $display("FAIL wait_sleep1 timeout got=%b exp=1", sleep1); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; clear = 0;
    idle_all();
    if1.req = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if1.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got=%b exp=0", if1.gnt); end
    checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL rst_sram_req got=%b exp=0", req1); end
    checks++; if (if1.r_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", if1.r_valid); end
    checks++; if (sleep1 !== 1'b0) begin errors++; $display("FAIL rst_sleep got=%b exp=0", sleep1); end
    @(negedge clk);
    if1.req = 0;
    rst = 0;
    #1;
    checks++; if (if1.gnt !== 1'b0) begin errors++; $display("FAIL post_rst_gnt got=%b exp=0", if1.gnt); end
    checks++; if (st1 !== BANK_ACTIVE) begin errors++; $display("FAIL post_rst_state got=%0d exp=%0d", st1, BANK_ACTIVE); end
    repeat (63) @(negedge clk);
    checks++; if (sleep1 !== 1'b0) begin errors++; $display("FAIL sleep_cycle64 got=%b exp=0", sleep1); end
    @(negedge clk);
    checks++; if (sleep1 !== 1'b1) begin errors++; $display("FAIL sleep_cycle65 got=%b exp=1", sleep1); end
    checks++; if (st1 !== BANK_SLEEP) begin errors++; $display("FAIL sleep_state got=%0d exp=%0d", st1, BANK_SLEEP); end
  endtask

  task automatic test_rd_lat1();
    do_reset();
    if1.req = 1; if1.wen = 0; if1.add = 32'h10; if1.data = 32'hDEADBEEF; if1.be = 4'hF;
    #1;
    checks++; if (if1.gnt !== 1'b1) begin errors++; $display("FAIL l1_wr_gnt got=%b exp=1", if1.gnt); end
    checks++; if (we1 !== 1'b1) begin errors++; $display("FAIL l1_wr_we got=%b exp=1", we1); end
    checks++; if (addr1 !== 12'h4) begin errors++; $display("FAIL l1_wr_addr got=%h exp=004", addr1); end
    checks++; if (wdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL l1_wr_data got=%h exp=deadbeef", wdata1); end
    checks++; if (be1 !== 4'hF) begin errors++; $display("FAIL l1_wr_be got=%h exp=f", be1); end
    @(negedge clk);
    if1.wen = 1; if1.id = 8'h05; if1.data = 0; if1.add = 32'hFFFF_0010;
    #1;
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL l1_rd_we got=%b exp=0", we1); end
    checks++; if (addr1 !== 12'h4) begin errors++; $display("FAIL l1_rd_addr got=%h exp=004", addr1); end
    checks++; if (if1.r_valid !== 1'b0) begin errors++; $display("FAIL l1_wr_no_rvalid got=%b exp=0", if1.r_valid); end
    @(negedge clk);
    if1.req = 0;
    #1;
    checks++; if (if1.r_valid !== 1'b1) begin errors++; $display("FAIL l1_rvalid got=%b exp=1", if1.r_valid); end
    checks++; if (if1.r_data !== 32'hDEADBEEF) begin errors++; $display("FAIL l1_rdata got=%h exp=deadbeef", if1.r_data); end
    checks++; if (if1.r_id !== 8'h05) begin errors++; $display("FAIL l1_rid got=%h exp=05", if1.r_id); end
    @(negedge clk);
    #1;
    checks++; if (if1.r_valid !== 1'b0) begin errors++; $display("FAIL l1_rvalid_drop got=%b exp=0", if1.r_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wdat [4];
    wdat[0] = 32'hA0A0_0001; wdat[1] = 32'hB1B1_0002; wdat[2] = 32'hC2C2_0003; wdat[3] = 32'hD3D3_0004;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if2.req = 1; if2.wen = 0; if2.add = 32'(i * 4); if2.data = wdat[i]; if2.be = 4'hF;
      #1;
      checks++; if (if2.gnt !== 1'b1) begin errors++; $display("FAIL b2b_wr_gnt%0d got=%b exp=1", i, if2.gnt); end
      @(negedge clk);
    end
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        if2.req = 1; if2.wen = 1; if2.add = 32'(k * 4); if2.id = 8'(k + 1);
      end else begin
        if2.req = 0;
      end
      #1;
      if (k < 4) begin
        checks++; if (if2.gnt !== 1'b1) begin errors++; $display("FAIL b2b_rd_gnt%0d got=%b exp=1", k, if2.gnt); end
      end
      checks++;
      if (if2.r_valid !== (k >= 2 && k < 6)) begin
        errors++; $display("FAIL b2b_rvalid_c%0d got=%b exp=%b", k, if2.r_valid, (k >= 2 && k < 6));
      end
      if (k >= 2 && k < 6) begin
        checks++; if (if2.r_id !== 8'(k - 1)) begin errors++; $display("FAIL b2b_rid_c%0d got=%h exp=%h", k, if2.r_id, 8'(k - 1)); end
        checks++; if (if2.r_data !== wdat[k-2]) begin errors++; $display("FAIL b2b_rdata_c%0d got=%h exp=%h", k, if2.r_data, wdat[k-2]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wake();
    do_reset();
    if1.req = 1; if1.wen = 0; if1.add = 32'h20; if1.data = 32'h1234_5678; if1.be = 4'hF;
    @(negedge clk);
    if1.req = 0;
    wait_sleep1();
    if1.req = 1; if1.wen = 1; if1.add = 32'h20; if1.id = 8'h09;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (if1.gnt !== 1'b0) begin errors++; $display("FAIL wake_gnt_c%0d got=%b exp=0", k, if1.gnt); end
      checks++; if (sleep1 !== (k == 0)) begin errors++; $display("FAIL wake_sleep_c%0d got=%b exp=%b", k, sleep1, (k == 0)); end
      @(negedge clk);
    end
    #1;
    checks++; if (if1.gnt !== 1'b1) begin errors++; $display("FAIL wake_gnt_resume got=%b exp=1", if1.gnt); end
    checks++; if (req1 !== 1'b1) begin errors++; $display("FAIL wake_sram_req got=%b exp=1", req1); end
    @(negedge clk);
    if1.req = 0;
    #1;
    checks++; if (if1.r_valid !== 1'b1) begin errors++; $display("FAIL wake_rvalid got=%b exp=1", if1.r_valid); end
    checks++; if (if1.r_data !== 32'h1234_5678) begin errors++; $display("FAIL wake_rdata got=%h exp=12345678", if1.r_data); end
    checks++; if (if1.r_id !== 8'h09) begin errors++; $display("FAIL wake_rid got=%h exp=09", if1.r_id); end
  endtask

  task automatic test_clear();
    do_reset();
    if2.req = 1; if2.wen = 0; if2.add = 32'h40; if2.data = 32'hCAFE_F00D; if2.be = 4'hF;
    @(negedge clk);
    if2.wen = 1; if2.id = 8'h07;
    #1;
    checks++; if (if2.gnt !== 1'b1) begin errors++; $display("FAIL clr_rd_gnt got=%b exp=1", if2.gnt); end
    @(negedge clk);
    clear = 1; if2.id = 8'h08;
    #1;
    checks++; if (if2.gnt !== 1'b0) begin errors++; $display("FAIL clr_gnt got=%b exp=0", if2.gnt); end
    checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL clr_sram_req got=%b exp=0", req2); end
    @(negedge clk);
    clear = 0; if2.req = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (if2.r_valid !== 1'b0) begin errors++; $display("FAIL clr_dropped_c%0d got=%b exp=0", k, if2.r_valid); end
      @(negedge clk);
    end
    if2.req = 1; if2.wen = 1; if2.add = 32'h40; if2.id = 8'h0A;
    #1;
    checks++; if (if2.gnt !== 1'b1) begin errors++; $display("FAIL clr_next_gnt got=%b exp=1", if2.gnt); end
    @(negedge clk);
    if2.req = 0;
    #1;
    checks++; if (if2.r_valid !== 1'b0) begin errors++; $display("FAIL clr_next_early got=%b exp=0", if2.r_valid); end
    @(negedge clk);
    #1;
    checks++; if (if2.r_valid !== 1'b1) begin errors++; $display("FAIL clr_next_rvalid got=%b exp=1", if2.r_valid); end
    checks++; if (if2.r_id !== 8'h0A) begin errors++; $display("FAIL clr_next_rid got=%h exp=0a", if2.r_id); end
    checks++; if (if2.r_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL clr_next_rdata got=%h exp=cafef00d", if2.r_data); end
  endtask

  task automatic test_clear_wake();
    do_reset();
    wait_sleep1();
    if1.req = 1; if1.wen = 1; if1.add = 32'h20; if1.id = 8'h03;
    @(negedge clk);
    #1;
    checks++; if (st1 !== BANK_WAKE) begin errors++; $display("FAIL cw_state_wake got=%0d exp=%0d", st1, BANK_WAKE); end
    clear = 1;
    #1;
    checks++; if (if1.gnt !== 1'b0) begin errors++; $display("FAIL cw_gnt got=%b exp=0", if1.gnt); end
    @(negedge clk);
    clear = 0;
    #1;
    checks++; if (st1 !== BANK_ACTIVE) begin errors++; $display("FAIL cw_state_active got=%0d exp=%0d", st1, BANK_ACTIVE); end
    checks++; if (sleep1 !== 1'b0) begin errors++; $display("FAIL cw_sleep got=%b exp=0", sleep1); end
    checks++; if (if1.gnt !== 1'b1) begin errors++; $display("FAIL cw_gnt_resume got=%b exp=1", if1.gnt); end
    @(negedge clk);
    if1.req = 0;
  endtask

  task automatic test_no_sleep();
    int seen = 0;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      if (sleep0 !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL nosleep_cycles got=%0d exp=0", seen); end
    checks++; if (st0 !== BANK_ACTIVE) begin errors++; $display("FAIL nosleep_state got=%0d exp=%0d", st0, BANK_ACTIVE); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1; clear = 0;
    idle_all();
    test_reset();
    test_rd_lat1();
    test_back_to_back();
    test_wake();
    test_clear();
    test_clear_wake();
    test_no_sleep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
